// File: rtl/uart_feedback_decoder.sv
// Game-link receive decoder: status bytes, tagged header+payload messages, error count, link watchdog (FEEDBACK_WATCHDOG_EN).
// Latency: one clock from the rx_valid cycle to every registered output.
// Backpressure: none; a byte is accepted on every rx_valid, including back-to-back cycles.
module uart_feedback_decoder #(
    parameter int PAYLOAD_TIMEOUT = 16384,
    parameter int LINK_TIMEOUT    = 1048576,
    parameter int ERR_W           = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rx_valid,
    input  logic [7:0]       rx_bits,
    output logic [3:0]       status,
    output logic             status_valid,
    output logic [3:0]       status_rise,
    output logic             msg_valid,
    output logic [5:0]       msg_tag,
    output logic [7:0]       msg_value,
    output logic [ERR_W-1:0] err_count,
    output logic             link_alive
);

    localparam int              PT_W    = $clog2(PAYLOAD_TIMEOUT + 1);
    localparam logic [PT_W-1:0] PT_LAST = PT_W'(PAYLOAD_TIMEOUT - 1);

    typedef enum logic {
        IDLE,
        WAIT_PAYLOAD
    } state_t;

    typedef enum logic [1:0] {
        KIND_BAD0   = 2'b00,
        KIND_STATUS = 2'b01,
        KIND_HEADER = 2'b10,
        KIND_BAD3   = 2'b11
    } kind_t;

    typedef struct packed {
        logic [5:0] field;
        kind_t      kind;
    } rx_byte_t;

    rx_byte_t        rx_byte;
    state_t          state;
    logic [PT_W-1:0] pt_cnt;
    logic [5:0]      tag_q;
    logic [3:0]      old_status;
    logic            err_event;

    assign rx_byte    = rx_byte_t'(rx_bits);
    assign old_status = status_valid ? status : 4'b0000;

    // A payload arriving on the expiry cycle wins over the timeout.
    always_comb begin
        err_event = 1'b0;
        if (state == IDLE) begin
            err_event = rx_valid && (rx_byte.kind == KIND_BAD0 || rx_byte.kind == KIND_BAD3);
        end else begin
            err_event = !rx_valid && (pt_cnt == PT_LAST);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            pt_cnt       <= '0;
            tag_q        <= '0;
            status       <= '0;
            status_valid <= 1'b0;
            status_rise  <= '0;
            msg_valid    <= 1'b0;
            msg_tag      <= '0;
            msg_value    <= '0;
        end else begin
            status_rise <= '0;
            msg_valid   <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        if (rx_byte.kind == KIND_STATUS) begin
                            status       <= rx_byte.field[3:0];
                            status_valid <= 1'b1;
                            status_rise  <= rx_byte.field[3:0] & ~old_status;
                        end else if (rx_byte.kind == KIND_HEADER) begin
                            tag_q  <= rx_byte.field;
                            pt_cnt <= '0;
                            state  <= WAIT_PAYLOAD;
                        end
                    end
                end
                WAIT_PAYLOAD: begin
                    if (rx_valid) begin
                        msg_valid <= 1'b1;
                        msg_tag   <= tag_q;
                        msg_value <= rx_bits;
                        state     <= IDLE;
                    end else if (pt_cnt == PT_LAST) begin
                        state <= IDLE;
                    end else begin
                        pt_cnt <= pt_cnt + PT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_count <= '0;
        end else if (err_event && (err_count != {ERR_W{1'b1}})) begin
            err_count <= err_count + ERR_W'(1);
        end
    end

`ifdef FEEDBACK_WATCHDOG_EN
    localparam int              LT_W    = $clog2(LINK_TIMEOUT + 1);
    localparam logic [LT_W-1:0] LT_MAX  = LT_W'(LINK_TIMEOUT);
    localparam logic [LT_W-1:0] LT_LAST = LT_W'(LINK_TIMEOUT - 1);

    logic [LT_W-1:0] wd_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_cnt     <= '0;
            link_alive <= 1'b0;
        end else if (rx_valid) begin
            wd_cnt     <= '0;
            link_alive <= 1'b1;
        end else if (wd_cnt != LT_MAX) begin
            wd_cnt <= wd_cnt + LT_W'(1);
            if (wd_cnt == LT_LAST) begin
                link_alive <= 1'b0;
            end
        end
    end
`else
    // Without the watchdog the flag is sticky from the first byte until reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            link_alive <= 1'b0;
        end else if (rx_valid) begin
            link_alive <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_feedback_decoder.sv
// Bench for uart_feedback_decoder: directed steps plus random traffic checked against a message-level model.
module tb_uart_feedback_decoder;

    localparam int PT      = 8;
    localparam int LT      = 32;
    localparam int EW      = 8;
    localparam int ERR_MAX = (1 << EW) - 1;

    logic          clock    = 1'b0;
    logic          reset    = 1'b1;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_bits  = 8'h00;
    logic [3:0]    status, status_rise;
    logic          status_valid, msg_valid, link_alive;
    logic [5:0]    msg_tag;
    logic [7:0]    msg_value;
    logic [EW-1:0] err_count;

    logic [3:0]    l_status, l_status_rise;
    logic          l_status_valid, l_msg_valid, l_link_alive;
    logic [5:0]    l_msg_tag;
    logic [7:0]    l_msg_value;
    logic [7:0]    l_err_count;

    always #5 clock = ~clock;

    uart_feedback_decoder #(.PAYLOAD_TIMEOUT(PT), .LINK_TIMEOUT(LT), .ERR_W(EW)) dut (
        .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_bits(rx_bits),
        .status(status), .status_valid(status_valid), .status_rise(status_rise),
        .msg_valid(msg_valid), .msg_tag(msg_tag), .msg_value(msg_value),
        .err_count(err_count), .link_alive(link_alive)
    );

    // Default-parameter instance: long payload window for the slow header/payload case.
    uart_feedback_decoder dut_l (
        .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_bits(rx_bits),
        .status(l_status), .status_valid(l_status_valid), .status_rise(l_status_rise),
        .msg_valid(l_msg_valid), .msg_tag(l_msg_tag), .msg_value(l_msg_value),
        .err_count(l_err_count), .link_alive(l_link_alive)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    bit         m_wait;
    int         m_since;
    logic [5:0] m_tag;
    logic [3:0] m_status;
    bit         m_sv;
    int         m_err;
    bit         m_alive;
    int         m_idle;
    logic [3:0] e_rise;
    bit         e_mv;
    logic [5:0] e_tag;
    logic [7:0] e_val;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wait = 0; m_since = 0; m_tag = '0; m_status = '0; m_sv = 0;
        m_err = 0; m_alive = 0; m_idle = 0;
        e_rise = '0; e_mv = 0; e_tag = '0; e_val = '0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] b);
        logic [3:0] prev;
        e_rise = '0;
        e_mv   = 0;
        if (v) begin
            if (m_wait) begin
                e_mv = 1; e_tag = m_tag; e_val = b; m_wait = 0;
            end else if (b[1:0] == 2'b01) begin
                prev     = m_sv ? m_status : 4'b0000;
                e_rise   = b[5:2] & ~prev;
                m_status = b[5:2];
                m_sv     = 1;
            end else if (b[1:0] == 2'b10) begin
                m_wait = 1; m_tag = b[7:2]; m_since = 0;
            end else if (m_err < ERR_MAX) begin
                m_err++;
            end
        end else if (m_wait) begin
            m_since++;
            if (m_since == PT) begin
                m_wait = 0;
                if (m_err < ERR_MAX) m_err++;
            end
        end
`ifdef FEEDBACK_WATCHDOG_EN
        if (v) begin
            m_idle = 0; m_alive = 1;
        end else begin
            m_idle++;
            if (m_idle >= LT) m_alive = 0;
        end
`else
        if (v) m_alive = 1;
`endif
    endtask

    task automatic check_all();
        chk("status", status, m_status);
        chk("status_valid", status_valid, m_sv);
        chk("status_rise", status_rise, e_rise);
        chk("msg_valid", msg_valid, e_mv);
        if (e_mv) begin
            chk("msg_tag", msg_tag, e_tag);
            chk("msg_value", msg_value, e_val);
        end
        chk("err_count", err_count, m_err);
        chk("link_alive", link_alive, m_alive);
    endtask

    task automatic cyc(input bit v, input logic [7:0] b);
        rx_valid = v;
        rx_bits  = b;
        @(posedge clock);
        model_step(v, b);
        #1;
        check_all();
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_status"}, {status_valid, status, status_rise}, 9'h0);
        chk({tag, "_msg"}, {msg_valid, msg_tag, msg_value}, 15'h0);
        chk({tag, "_err"}, err_count, 0);
        chk({tag, "_alive"}, link_alive, 1'b0);
    endtask

    task automatic hard_reset();
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk_all_zero("rst");
        @(negedge clock);
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        #3 reset = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        chk_all_zero("reset_state");
        @(negedge clock);
        reset = 1'b1;

        // Status bytes and rising edges
        cyc(1'b1, 8'h15);
        chk("t1_status", status, 4'b0101);
        chk("t1_rise", status_rise, 4'b0101);
        cyc(1'b0, 8'h00);
        chk("t1_rise_clear", status_rise, 4'b0000);
        cyc(1'b1, 8'h3D);
        chk("t1_status2", status, 4'b1111);
        chk("t1_rise2", status_rise, 4'b1010);
        idle(2);

        // Header/payload 10 cycles apart: fine for the long window, a timeout for PT=8
        cyc(1'b1, 8'hAA);
        idle(9);
        cyc(1'b1, 8'h7F);
        chk("t2_long_mv", l_msg_valid, 1'b1);
        chk("t2_long_tag", l_msg_tag, 6'h2A);
        chk("t2_long_val", l_msg_value, 8'h7F);
        chk("t2_long_err", l_err_count, 8'h00);
        cyc(1'b1, 8'hAA);
        idle(3);
        cyc(1'b1, 8'h7F);
        chk("t2_mv", msg_valid, 1'b1);
        chk("t2_tag", msg_tag, 6'h2A);

        // Async reset in the middle of a header/payload pair aborts the message
        cyc(1'b1, 8'hAA);
        #2 reset = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        cyc(1'b1, 8'h7F);
        chk("abort_mv", msg_valid, 1'b0);
        chk("abort_err", err_count, 1);

        // Payload timeout
        hard_reset();
        cyc(1'b1, 8'h06);
        idle(7);
        chk("t3_err_before", err_count, 0);
        idle(1);
        chk("t3_err", err_count, 1);
        cyc(1'b1, 8'h05);
        chk("t3_status", status, 4'b0001);
        chk("t3_mv", msg_valid, 1'b0);

        // Payload exactly on the expiry cycle
        cyc(1'b1, 8'h0A);
        idle(7);
        cyc(1'b1, 8'h02);
        chk("t5_mv", msg_valid, 1'b1);
        chk("t5_tag", msg_tag, 6'h02);
        chk("t5_val", msg_value, 8'h02);
        chk("t5_err", err_count, 1);

        // Error saturation, back-to-back bytes
        hard_reset();
        cyc(1'b1, 8'h00);
        chk("t4_err1", err_count, 1);
        cyc(1'b1, 8'hFF);
        chk("t4_err2", err_count, 2);
        for (int i = 0; i < 300; i++) cyc(1'b1, 8'h03);
        chk("t4_sat", err_count, 255);

        // Link watchdog
        hard_reset();
        cyc(1'b1, 8'h05);
        chk("t6_alive", link_alive, 1'b1);
        idle(LT - 1);
        chk("t6_alive_hold", link_alive, 1'b1);
        idle(1);
`ifdef FEEDBACK_WATCHDOG_EN
        chk("t6_alive_drop", link_alive, 1'b0);
`else
        chk("t6_alive_sticky", link_alive, 1'b1);
`endif
        idle(5);
        cyc(1'b1, 8'h09);
        chk("t6_alive_back", link_alive, 1'b1);

        // Random traffic, biased toward headers, with idle gaps around the timeout
        hard_reset();
        for (int n = 0; n < 500; n++) begin
            logic [7:0] b;
            b = 8'($urandom);
            if ($urandom_range(0, 2) == 0) b[1:0] = 2'b10;
            cyc(1'b1, b);
            if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 10));
            if ($urandom_range(0, 40) == 0) idle($urandom_range(25, 40));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
